// File: rtl/updown_counter_prog.sv
// updown_counter_prog: programmable-range up/down counter with variable step, load, tc and err pulses.
// Saturating mode (port sat) is compiled in only when UDC_SAT_EN is defined.
module updown_counter_prog #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              ld,
    input  logic [WIDTH-1:0]  d,
    input  logic              u_d,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  lo,
    input  logic [WIDTH-1:0]  hi,
`ifdef UDC_SAT_EN
    input  logic              sat,
`endif
    output logic [WIDTH-1:0]  q,
    output logic              tc,
    output logic              err
);
    logic [WIDTH-1:0] r_q;
    logic             r_tc;
    logic             r_err;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH:0]   w_up_room;
    logic [WIDTH:0]   w_dn_room;
    logic             w_fit_up;
    logic             w_fit_dn;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_dif;
    logic [WIDTH-1:0] w_wrap_up;
    logic [WIDTH-1:0] w_wrap_dn;
    logic             w_cfg_bad;
    logic             w_d_ok;
    logic             w_q_ok;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_tc_nxt;
    logic             w_err_nxt;

    assign w_step    = WIDTH'(step);
    assign w_cfg_bad = lo > hi;
    assign w_d_ok    = (d >= lo) && (d <= hi);
    assign w_q_ok    = (r_q >= lo) && (r_q <= hi);
    // Headroom is only meaningful while q is in range, which is checked first.
    assign w_up_room = {1'b0, hi} - {1'b0, r_q};
    assign w_dn_room = {1'b0, r_q} - {1'b0, lo};
    assign w_fit_up  = w_up_room >= {1'b0, w_step};
    assign w_fit_dn  = w_dn_room >= {1'b0, w_step};
    assign w_sum     = r_q + w_step;
    assign w_dif     = r_q - w_step;

`ifdef UDC_SAT_EN
    assign w_wrap_up = sat ? hi : lo;
    assign w_wrap_dn = sat ? lo : hi;
`else
    assign w_wrap_up = lo;
    assign w_wrap_dn = hi;
`endif

    always_comb begin
        w_q_nxt   = r_q;
        w_tc_nxt  = 1'b0;
        w_err_nxt = 1'b0;
        if (w_cfg_bad) begin
            w_err_nxt = ld | en;
        end else if (ld) begin
            w_q_nxt   = w_d_ok ? d : lo;
            w_err_nxt = !w_d_ok;
        end else if (en) begin
            if (!w_q_ok) begin
                w_q_nxt   = u_d ? lo : hi;
                w_err_nxt = 1'b1;
            end else if (w_step != '0) begin
                if (u_d) begin
                    w_q_nxt  = w_fit_up ? w_sum : w_wrap_up;
                    w_tc_nxt = !w_fit_up || (w_sum == hi);
                end else begin
                    w_q_nxt  = w_fit_dn ? w_dif : w_wrap_dn;
                    w_tc_nxt = !w_fit_dn || (w_dif == lo);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q   <= '0;
            r_tc  <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_q   <= w_q_nxt;
            r_tc  <= w_tc_nxt;
            r_err <= w_err_nxt;
        end
    end

    assign q   = r_q;
    assign tc  = r_tc;
    assign err = r_err;
endmodule

// File: tb/tb_updown_counter_prog.sv
// tb_updown_counter_prog: directed test-plan sequences plus randomized traffic against an integer model.
module tb_updown_counter_prog;
    localparam int W  = 8;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          ld = 1'b0;
    logic [W-1:0]  d = '0;
    logic          u_d = 1'b1;
    logic [SW-1:0] step = '0;
    logic [W-1:0]  lo = '0;
    logic [W-1:0]  hi = '1;
    logic          sat = 1'b0;
    logic [W-1:0]  q;
    logic          tc;
    logic          err;

    int n_chk = 0;
    int n_err = 0;
    int m_q = 0;
    int m_tc = 0;
    int m_err = 0;
    bit m_valid = 0;

    updown_counter_prog #(.WIDTH(W), .STEP_W(SW)) dut (
        .clk(clk), .rst(rst), .en(en), .ld(ld), .d(d), .u_d(u_d), .step(step),
        .lo(lo), .hi(hi),
`ifdef UDC_SAT_EN
        .sat(sat),
`endif
        .q(q), .tc(tc), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the counter rules.
    always @(posedge clk) begin
        int lv, hv, qv, st, t;
        bit sat_on;
        lv = int'(lo); hv = int'(hi); st = int'(step); qv = m_q;
`ifdef UDC_SAT_EN
        sat_on = sat;
`else
        sat_on = 0;
`endif
        m_tc = 0; m_err = 0;
        if (rst) begin
            m_q = 0;
        end else if ((ld || en) && lv > hv) begin
            m_err = 1;
        end else if (ld) begin
            if (int'(d) >= lv && int'(d) <= hv) m_q = int'(d);
            else begin m_q = lv; m_err = 1; end
        end else if (en) begin
            if (qv < lv || qv > hv) begin
                m_q = u_d ? lv : hv; m_err = 1;
            end else if (st != 0) begin
                t = u_d ? qv + st : qv - st;
                if (t >= lv && t <= hv) begin
                    m_q = t; m_tc = (t == (u_d ? hv : lv)) ? 1 : 0;
                end else begin
                    m_q = (u_d ^ sat_on) ? lv : hv; m_tc = 1;
                end
            end
        end
        m_valid = 1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_q", 32'(q), 32'(m_q));
            chk("model_tc", 32'(tc), 32'(m_tc));
            chk("model_err", 32'(err), 32'(m_err));
        end
    end

    task automatic apply(input logic r, input logic l, input logic e, input int dv, input logic ud,
                         input int st, input int lv, input int hv);
        rst = r; ld = l; en = e; d = W'(dv); u_d = ud; step = SW'(st); lo = W'(lv); hi = W'(hv);
        @(negedge clk);
    endtask

    task automatic lit(input string nm, input int eq, input int etc, input int eerr);
        chk({nm, "_q"}, 32'(q), 32'(eq));
        chk({nm, "_tc"}, 32'(tc), 32'(etc));
        chk({nm, "_err"}, 32'(err), 32'(eerr));
    endtask

    initial begin
        // Reset and hold
        apply(1, 0, 0, 0, 1, 0, 0, 255); lit("rst0", 0, 0, 0);
        apply(1, 0, 0, 0, 1, 0, 0, 255); lit("rst1", 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0, 0, 1, 0, 0, 255); lit("hold", 0, 0, 0);
        end
        // Up wrap
        apply(0, 1, 0, 18, 1, 3, 10, 20); lit("upld", 18, 0, 0);
        apply(0, 0, 1, 0, 1, 3, 10, 20); lit("upw1", 10, 1, 0);
        apply(0, 0, 1, 0, 1, 3, 10, 20); lit("up13", 13, 0, 0);
        apply(0, 0, 1, 0, 1, 3, 10, 20); lit("up16", 16, 0, 0);
        apply(0, 0, 1, 0, 1, 3, 10, 20); lit("up19", 19, 0, 0);
        apply(0, 0, 1, 0, 1, 3, 10, 20); lit("upw2", 10, 1, 0);
        // Down exact bound
        apply(0, 1, 0, 14, 0, 2, 10, 20); lit("dnld", 14, 0, 0);
        apply(0, 0, 1, 0, 0, 2, 10, 20); lit("dn12", 12, 0, 0);
        apply(0, 0, 1, 0, 0, 2, 10, 20); lit("dnlo", 10, 1, 0);
        apply(0, 0, 1, 0, 0, 2, 10, 20); lit("dnwr", 20, 1, 0);
        apply(0, 0, 1, 0, 0, 2, 10, 20); lit("dn18", 18, 0, 0);
        // Load and config violations
        apply(0, 1, 0, 5, 0, 2, 10, 20); lit("ldbad", 10, 0, 1);
        apply(0, 0, 1, 0, 1, 2, 30, 20); lit("cfg1", 10, 0, 1);
        apply(0, 0, 1, 0, 1, 2, 30, 20); lit("cfg2", 10, 0, 1);
        apply(0, 0, 0, 0, 1, 2, 30, 20); lit("cfgidle", 10, 0, 0);
        // lo=hi
        apply(0, 0, 1, 0, 1, 5, 7, 7); lit("eqoor", 7, 0, 1);
        apply(0, 0, 1, 0, 1, 5, 7, 7); lit("equp", 7, 1, 0);
        apply(0, 0, 1, 0, 0, 1, 7, 7); lit("eqdn", 7, 1, 0);
        // Priority
        apply(0, 1, 1, 15, 1, 3, 10, 20); lit("ldwin", 15, 0, 0);
        apply(1, 1, 1, 17, 1, 3, 10, 20); lit("rstwin", 0, 0, 0);
`ifdef UDC_SAT_EN
        sat = 1'b1;
        apply(0, 1, 0, 250, 1, 8, 0, 255); lit("satld", 250, 0, 0);
        apply(0, 0, 1, 0, 1, 8, 0, 255); lit("sat1", 255, 1, 0);
        apply(0, 0, 1, 0, 1, 8, 0, 255); lit("sat2", 255, 1, 0);
        sat = 1'b0;
        apply(0, 1, 0, 250, 1, 8, 0, 255); lit("wrld", 250, 0, 0);
        apply(0, 0, 1, 0, 1, 8, 0, 255); lit("wrap", 0, 1, 0);
`endif
        // Randomized traffic; bounds change only occasionally so counting runs develop.
        begin
            int lv, hv, ud;
            lv = 10; hv = 200; ud = 1;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 39) == 0) begin
                    lv = $urandom_range(0, 255);
                    hv = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(lv, 255);
                end
                if ($urandom_range(0, 15) == 0) ud = ~ud & 1;
`ifdef UDC_SAT_EN
                if ($urandom_range(0, 31) == 0) sat = ~sat;
`endif
                apply($urandom_range(0, 99) == 0, $urandom_range(0, 9) == 0,
                      $urandom_range(0, 3) != 0, $urandom_range(0, 255), ud[0],
                      $urandom_range(0, 15), lv, hv);
            end
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/updown_counter_prog.md
# updown_counter_prog

Parametrised, programmable-range up/down counter with variable step, synchronous load, count enable, and a terminal-count pulse. It replaces fixed 4-bit up/down counters in timer, address-sequencing and PWM-period datapaths where the range and step are set at run time. All outputs are registered. An optional saturation mode is compiled in by macro.

## Interface
Parameters:
- WIDTH, 8, counter, data and bound width (≥2)
- STEP_W, 4, step input width (STEP_W ≤ WIDTH)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high; clock clk
- en  in  1  count enable
- ld  in  1  synchronous load of d
- d  in  WIDTH  load value
- u_d  in  1  direction: 1 = up, 0 = down
- step  in  STEP_W  increment magnitude, unsigned
- lo  in  WIDTH  lower bound, inclusive
- hi  in  WIDTH  upper bound, inclusive
- sat  in  1  saturate instead of wrap (present only with UDC_SAT_EN)
- q  out  WIDTH  count value
- tc  out  1  one-cycle pulse when a count crosses or reaches a bound
- err  out  1  one-cycle pulse on a range or config violation

## Operation
- Priority per cycle: rst > ld > en. When none is asserted, q holds and tc=err=0.
- Config check: lo > hi is invalid. While invalid, ld and en have no effect on q, and err=1 every cycle ld or en is asserted.
- Load: if lo ≤ d ≤ hi, then q←d and err=0. Otherwise q←lo and err=1. tc=0.
- Count, with en=1, ld=0 and a valid config:
  - If q is outside [lo,hi], q←lo when up and q←hi when down. err=1, tc=0.
  - step=0: q holds, tc=0.
  - Up, when (hi−q) ≥ step: q←q+step. tc=1 if the result equals hi.
  - Up, when (hi−q) < step: wrap, q←lo. Any remainder is discarded. tc=1.
  - Down, when (q−lo) ≥ step: q←q−step. tc=1 if the result equals lo.
  - Down, when (q−lo) < step: wrap, q←hi. tc=1.
- Arithmetic: differences are computed in WIDTH+1 bits and step is zero-extended to WIDTH. There is no modular overflow of q; q stays within [lo,hi] after any valid count.
- lo=hi: every non-zero count leaves q=lo and pulses tc.
- lo and hi are sampled combinationally each cycle. Changing them mid-count takes effect on the next count, with the out-of-range rule above applying.

## Timing
- Reset values: q=0, tc=0, err=0.
- Latency: every effect appears one clock after the sampling edge. q, tc and err update on the same edge.
- tc and err are single-cycle unless the triggering condition repeats in the next cycle.
- rst asserted mid-count overrides ld and en in that cycle. There is no pending state after reset.
- No handshake. en may be held continuously, giving one count per clock.

## Configuration
- Macro UDC_SAT_EN.
- Defined: port sat exists. With sat=1, a count that would wrap instead clamps (up: q←hi; down: q←lo) and pulses tc. A count with q already at the bound holds q and pulses tc every cycle. With sat=0, behaviour is the wrap behaviour above.
- Undefined: port sat is absent and the counter always wraps. The RTL must contain no saturation logic.

## Test plan
- Reset and hold: rst=1 for 2 cycles, then en=0 for 3 cycles → q=0, tc=0 and err=0 throughout.
- Up wrap: lo=10, hi=20, ld d=18, then en=1, u_d=1, step=3 → q=18, then 10 with tc=1 in that cycle, then 13, 16, 19, then 10 with tc=1.
- Down exact bound: lo=10, hi=20, ld d=14, u_d=0, step=2 → q=12, then 10 with tc=1, then 20 with tc=1, then 18.
- Load violations: lo=10, hi=20, ld d=5 → q=10, err=1. Then lo=30, hi=20 with en=1 → q holds, err=1 each cycle.
- Priority: ld=1 and en=1 with d=15 → q=15 (load wins). rst=1 and ld=1 → q=0.
- With UDC_SAT_EN: sat=1, lo=0, hi=255, q=250, up, step=8 → q=255 and tc=1. The next count holds q=255 with tc=1. Repeat with sat=0 → q=0 with tc=1.
